// File: rtl/fft_pkg.sv
//==============================================================
// fft_pkg: shared types, defaults and helpers for the FFT RAM controller. Rev 1.0
//==============================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_N    = 16;
  localparam int FFT_SIZE = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_READ     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
//==============================================================
// fft_addr_gen: combinational butterfly read address / twiddle index. Rev 1.0
//==============================================================
`default_nettype none

module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int SIZE = FFT_SIZE
) (
  input  logic [SIZE-1:0] rd_cnt,
  input  logic [SIZE-1:0] stage,
  output logic [SIZE-1:0] rd_ptr,
  output logic [SIZE-2:0] rd_angle_ptr
);

  localparam logic [SIZE-1:0] C_ONE      = SIZE'(1);
  localparam logic [SIZE-1:0] C_TOP_BIT  = SIZE'(SIZE - 1);

  logic [SIZE-1:0] w_j;
  logic [SIZE-1:0] w_half;
  logic [SIZE-1:0] w_mask;
  logic [SIZE-1:0] w_top;
  logic [SIZE-1:0] w_shamt;

  always_comb begin
    w_j     = rd_cnt >> 1;
    w_half  = C_ONE << stage;
    w_mask  = w_half - C_ONE;
    // Group base spreads by 2*half; offset inside the group stays put.
    w_top   = ((w_j >> stage) << (stage + C_ONE)) | (w_j & w_mask);
    rd_ptr  = rd_cnt[0] ? (w_top + w_half) : w_top;
    w_shamt = C_TOP_BIT - stage;
    rd_angle_ptr = (SIZE-1)'((w_j & w_mask) << w_shamt);
  end

endmodule

`default_nettype wire

// File: rtl/fft_ram_ctrl.sv
//==============================================================
// fft_ram_ctrl: FFT RAM load/read sequencer. Rev 1.0
// Define FFT_CTRL_OVERRUN_EN to enable the sticky overrun detector.
//==============================================================
`default_nettype none

module fft_ram_ctrl
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int SIZE = FFT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic            stage_ack,
  output logic            load_data,
  output logic [SIZE-1:0] invert_adr,
  output logic            en_rd,
  output logic [SIZE-1:0] rd_ptr,
  output logic [SIZE-2:0] rd_angle_ptr,
  output logic [SIZE-1:0] stage,
  output logic            busy,
  output logic            fft_done,
  output logic            overrun
);

  localparam logic [SIZE-1:0] C_LAST_CNT   = SIZE'(N - 1);
  localparam logic [SIZE-1:0] C_LAST_STAGE = SIZE'(SIZE - 1);
  localparam logic [SIZE-1:0] C_ONE        = SIZE'(1);

  state_t          state;
  logic [SIZE-1:0] wr_cnt;
  logic [SIZE-1:0] rd_cnt;
  logic [SIZE-1:0] w_rd_ptr;
  logic [SIZE-2:0] w_rd_angle_ptr;

  fft_addr_gen #(
    .SIZE (SIZE)
  ) u_addr_gen (
    .rd_cnt       (rd_cnt),
    .stage        (stage),
    .rd_ptr       (w_rd_ptr),
    .rd_angle_ptr (w_rd_angle_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      load_data    <= 1'b0;
      invert_adr   <= '0;
      en_rd        <= 1'b0;
      rd_ptr       <= '0;
      rd_angle_ptr <= '0;
      stage        <= '0;
      busy         <= 1'b0;
      fft_done     <= 1'b0;
    end else begin
      load_data <= 1'b0;
      en_rd     <= 1'b0;
      fft_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            busy   <= 1'b1;
            wr_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            load_data  <= 1'b1;
            invert_adr <= SIZE'(bitrev(32'(wr_cnt), SIZE));
            wr_cnt     <= wr_cnt + C_ONE;
            if (wr_cnt == C_LAST_CNT) begin
              state  <= S_READ;
              stage  <= '0;
              rd_cnt <= '0;
            end
          end
        end
        // Outputs trail rd_cnt by one edge, so en_rd spans exactly N cycles.
        S_READ: begin
          en_rd        <= 1'b1;
          rd_ptr       <= w_rd_ptr;
          rd_angle_ptr <= w_rd_angle_ptr;
          rd_cnt       <= rd_cnt + C_ONE;
          if (rd_cnt == C_LAST_CNT) begin
            state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (stage_ack) begin
            if (stage == C_LAST_STAGE) begin
              state    <= S_DONE;
              fft_done <= 1'b1;
            end else begin
              state  <= S_READ;
              stage  <= stage + C_ONE;
              rd_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          stage <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_CTRL_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      overrun <= 1'b0;
    end else if (in_valid && (state != S_LOAD)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_ram_ctrl.sv
//==============================================================
// tb_fft_ram_ctrl: randomized self-checking bench for fft_ram_ctrl. Rev 1.0
//==============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_ram_ctrl;

  localparam int N    = 16;
  localparam int SIZE = 4;
`ifdef FFT_CTRL_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            stage_ack = 1'b0;
  logic            load_data;
  logic [SIZE-1:0] invert_adr;
  logic            en_rd;
  logic [SIZE-1:0] rd_ptr;
  logic [SIZE-2:0] rd_angle_ptr;
  logic [SIZE-1:0] stage;
  logic            busy;
  logic            fft_done;
  logic            overrun;

  int tests = 0;
  int fails = 0;
  bit exp_ovr = 1'b0;
  int exp_ptr[N];
  int exp_ang[N];

  fft_ram_ctrl #(.N(N), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .stage_ack    (stage_ack),
    .load_data    (load_data),
    .invert_adr   (invert_adr),
    .en_rd        (en_rd),
    .rd_ptr       (rd_ptr),
    .rd_angle_ptr (rd_angle_ptr),
    .stage        (stage),
    .busy         (busy),
    .fft_done     (fft_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev_ref(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < SIZE; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Butterfly order: groups of 2*half, top then bottom of each pair.
  task automatic build_stage(input int s);
    int half = 1 << s;
    int idx = 0;
    for (int g = 0; g < N / (2 * half); g++) begin
      for (int k = 0; k < half; k++) begin
        exp_ptr[idx]     = g * 2 * half + k;
        exp_ptr[idx + 1] = g * 2 * half + k + half;
        exp_ang[idx]     = k * (N / (2 * half));
        exp_ang[idx + 1] = k * (N / (2 * half));
        idx += 2;
      end
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_ovr = 1'b0;
    tests++;
    if (busy !== 1'b1 || load_data !== 1'b0 || en_rd !== 1'b0 || overrun !== exp_ovr) begin
      fails++;
      $display("FAIL start_accept: busy=%b load=%b en_rd=%b ovr=%b, expected busy=1 load=0 en_rd=0 ovr=%b",
               busy, load_data, en_rd, overrun, exp_ovr);
    end
  endtask

  // mode 0: back-to-back, 1: toggling 1/0, 2: random gaps
  task automatic do_load(input int mode);
    int accepted = 0;
    int pulses = 0;
    int cyc = 0;
    logic [SIZE-1:0] ea;
    while (accepted < N && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom % 2 == 0);
      endcase
      tick;
      cyc++;
      ea = SIZE'(bitrev_ref(accepted));
      if (load_data === 1'b1) pulses++;
      tests++;
      if (in_valid) begin
        if (load_data !== 1'b1 || invert_adr !== ea || en_rd !== 1'b0) begin
          fails++;
          $display("FAIL load_sample%0d: load=%b adr=%0d en_rd=%b, expected load=1 adr=%0d en_rd=0",
                   accepted, load_data, invert_adr, en_rd, ea);
        end
        accepted++;
      end else if (load_data !== 1'b0 || en_rd !== 1'b0) begin
        fails++;
        $display("FAIL load_gap: load=%b en_rd=%b, expected 0 0", load_data, en_rd);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (accepted != N || pulses != N) begin
      fails++;
      $display("FAIL load_count: accepted=%0d pulses=%0d, expected %0d", accepted, pulses, N);
    end
  endtask

  task automatic do_stage(input int s, input int n_reads, input int ack_delay, input bit ovr_inject);
    logic [SIZE-1:0] ep;
    logic [SIZE-2:0] ea;
    build_stage(s);
    for (int i = 0; i < n_reads; i++) begin
      stage_ack = ($urandom % 4 == 0);
      start     = ($urandom % 4 == 0);
      tick;
      ep = SIZE'(exp_ptr[i]);
      ea = (SIZE-1)'(exp_ang[i]);
      tests++;
      if (en_rd !== 1'b1 || rd_ptr !== ep || rd_angle_ptr !== ea || stage !== SIZE'(s) ||
          fft_done !== 1'b0 || busy !== 1'b1 || overrun !== exp_ovr) begin
        fails++;
        $display("FAIL read_s%0d_c%0d: en_rd=%b ptr=%0d ang=%0d stage=%0d done=%b ovr=%b, expected 1 %0d %0d %0d 0 %b",
                 s, i, en_rd, rd_ptr, rd_angle_ptr, stage, fft_done, overrun, ep, ea, s, exp_ovr);
      end
    end
    stage_ack = 1'b0;
    start = 1'b0;
    if (n_reads < N) return;
    for (int d = 0; d < ack_delay; d++) begin
      in_valid = ovr_inject && (d == 0);
      tick;
      if (in_valid) exp_ovr = OVR_EN;
      tests++;
      if (en_rd !== 1'b0 || fft_done !== 1'b0 || busy !== 1'b1 || load_data !== 1'b0 || overrun !== exp_ovr) begin
        fails++;
        $display("FAIL wait_ack_s%0d: en_rd=%b done=%b busy=%b load=%b ovr=%b, expected 0 0 1 0 %b",
                 s, en_rd, fft_done, busy, load_data, overrun, exp_ovr);
      end
    end
    in_valid = 1'b0;
    stage_ack = 1'b1;
    tick;
    stage_ack = 1'b0;
    if (s < SIZE - 1) begin
      tests++;
      if (stage !== SIZE'(s + 1) || en_rd !== 1'b0 || fft_done !== 1'b0) begin
        fails++;
        $display("FAIL ack_s%0d: stage=%0d en_rd=%b done=%b, expected %0d 0 0", s, stage, en_rd, fft_done, s + 1);
      end
    end else begin
      tests++;
      if (fft_done !== 1'b1 || busy !== 1'b1 || en_rd !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse: done=%b busy=%b en_rd=%b, expected 1 1 0", fft_done, busy, en_rd);
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      tests++;
      if (fft_done !== 1'b0 || busy !== 1'b0 || stage !== '0) begin
        fails++;
        $display("FAIL done_end: done=%b busy=%b stage=%0d, expected 0 0 0", fft_done, busy, stage);
      end
      tick;
      tests++;
      if (busy !== 1'b0 || fft_done !== 1'b0 || overrun !== exp_ovr) begin
        fails++;
        $display("FAIL idle_after_done: busy=%b done=%b ovr=%b, expected 0 0 %b", busy, fft_done, overrun, exp_ovr);
      end
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({load_data, invert_adr, en_rd, rd_ptr, rd_angle_ptr, stage, busy, fft_done, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {load_data, invert_adr, en_rd, rd_ptr, rd_angle_ptr, stage, busy, fft_done, overrun});
    end
    tick;
    tick;
    #2 rst_n = 1'b1;
    stage_ack = 1'b1;
    tick;
    stage_ack = 1'b0;
    tests++;
    if (busy !== 1'b0 || en_rd !== 1'b0 || fft_done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b en_rd=%b done=%b, expected 0 0 0", busy, en_rd, fft_done);
    end
  endtask

  task automatic test_full_frame;
    do_start;
    do_load(0);
    for (int s = 0; s < SIZE; s++) do_stage(s, N, 4, 1'b0);
  endtask

  task automatic test_gapped_load;
    do_start;
    do_load(1);
    for (int s = 0; s < SIZE; s++) do_stage(s, N, int'($urandom_range(0, 6)), 1'b0);
    do_start;
    do_load(2);
    for (int s = 0; s < SIZE; s++) do_stage(s, N, int'($urandom_range(0, 6)), 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    do_start;
    do_load(0);
    do_stage(0, N, 2, 1'b0);
    do_stage(1, N, 2, 1'b0);
    do_stage(2, 5, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_ovr = 1'b0;
    tests++;
    if ({load_data, invert_adr, en_rd, rd_ptr, rd_angle_ptr, stage, busy, fft_done, overrun} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got %b, expected all zero",
               {load_data, invert_adr, en_rd, rd_ptr, rd_angle_ptr, stage, busy, fft_done, overrun});
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stage_ack = 1'b1;
      tick;
      tests++;
      if (fft_done !== 1'b0 || busy !== 1'b0 || en_rd !== 1'b0) begin
        fails++;
        $display("FAIL abandoned_frame: done=%b busy=%b en_rd=%b, expected 0 0 0", fft_done, busy, en_rd);
      end
    end
    stage_ack = 1'b0;
    test_full_frame;
  endtask

  task automatic test_overrun;
    do_start;
    do_load(0);
    do_stage(0, N, 3, 1'b1);
    for (int s = 1; s < SIZE; s++) do_stage(s, N, 2, 1'b0);
    tests++;
    if (overrun !== exp_ovr) begin
      fails++;
      $display("FAIL overrun_held: ovr=%b, expected %b", overrun, exp_ovr);
    end
    do_start;
    do_load(0);
    for (int s = 0; s < SIZE; s++) do_stage(s, N, 1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_gapped_load;
    test_reset_mid_frame;
    test_overrun;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
